// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the clk_div_bank divider bank.
//   DIV_W_DEFAULT : default divisor register width
//   MAX_CH        : largest supported channel count
//   ceil_half(n)  : ceil(n/2); sets how many cycles clk_out stays high in an
//                   n-cycle period
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DIV_W_DEFAULT = 8;
    localparam int MAX_CH        = 16;

    function automatic int unsigned ceil_half(input int unsigned n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider channel. It counts 0..div_act, so the period is N = div_act+1
// cycles. It emits a strobe on the last cycle of each period and a registered
// near-50% clock. It also holds a shadow divisor that is applied only at a
// period boundary.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   run enable (level)
//   wr       in   write strobe already decoded for this channel
//   div_in   in   divisor value being written
//   sync     in   force a new period; ignored as a boundary strobe
//   tick     out  one-cycle strobe on the last cycle of each period
//   clk_out  out  registered divided clock, high for ceil(N/2) cycles
//   pending  out  a written divisor waits for the next boundary
// -----------------------------------------------------------------------------
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] div_in,
    input  logic             sync,
    output logic             tick,
    output logic             clk_out,
    output logic             pending
);

    logic [DIV_W-1:0] cnt_q,      cnt_d;
    logic [DIV_W-1:0] div_act_q,  div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q,     pend_d;
    logic             clk_out_q,  clk_out_d;
    logic             boundary;
    logic [DIV_W:0]   half_d;

    assign boundary = (cnt_q == div_act_q);

    // rst_n gates the strobe so that tick reads 0 during reset, as the other
    // outputs do, even while en is high.
    assign tick    = rst_n & en & boundary & ~sync;
    assign clk_out = clk_out_q;
    assign pending = pend_q;

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;

        // Disable, sync and a natural boundary all start a new period. Each one
        // takes a same-cycle write directly. If there is no write, it commits
        // any shadowed value.
        if (!en || sync || boundary) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (wr) begin
                div_act_d = div_in;
            end else if (pend_q) begin
                div_act_d = div_pend_q;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (wr) begin
                div_pend_d = div_in;
                pend_d     = 1'b1;
            end
        end

        // N = div+1 can reach 2**DIV_W, so the threshold uses one extra bit.
        half_d    = (DIV_W+1)'(ceil_half(32'(div_act_d) + 32'd1));
        clk_out_d = en && ({1'b0, cnt_d} < half_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_act_q  <= '0;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// A bank of NUM_CH independent programmable clock-enable generators. Channel i
// divides clk by (div+1). Divisor writes are shadowed until a period boundary.
//
// Optional build macro: CLK_DIV_BANK_SYNC_EN adds the sync_in port. A pulse on
// it restarts every enabled channel at count 0 and commits pending divisors.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   wr       in   divisor write strobe
//   ch_sel   in   channel addressed by wr; values >= NUM_CH are ignored
//   div_in   in   divisor written (ratio = div_in + 1)
//   en       in   per-channel run enable
//   tick     out  per-channel end-of-period strobe
//   clk_out  out  per-channel registered divided clock
//   pending  out  per-channel shadow-divisor-waiting flag
//   sync_in  in   (CLK_DIV_BANK_SYNC_EN only) phase-align all channels
// -----------------------------------------------------------------------------
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = DIV_W_DEFAULT,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [DIV_W-1:0]  div_in,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] pending
`ifdef CLK_DIV_BANK_SYNC_EN
    ,
    input  logic              sync_in
`endif
);

    logic [NUM_CH-1:0] wr_ch;
    logic              sync;

`ifdef CLK_DIV_BANK_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    // An out-of-range ch_sel matches no channel, so the write is dropped.
    always_comb begin
        wr_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ch[i] = wr && (32'(ch_sel) == 32'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[g]),
            .wr      (wr_ch[g]),
            .div_in  (div_in),
            .sync    (sync),
            .tick    (tick[g]),
            .clk_out (clk_out[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;
    localparam int CH_W   = 3;   // wide enough to address the out-of-range channel 5

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr;
    logic [CH_W-1:0]   ch_sel;
    logic [DIV_W-1:0]  div_in;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] pending;
`ifdef CLK_DIV_BANK_SYNC_EN
    logic              sync_in;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] en;
        logic       wr;
        logic [2:0] sel;
        logic [7:0] din;
        logic       sync;
        logic [3:0] tick;
        logic [3:0] clko;
        logic [3:0] pend;
        logic       chk;
    } row_t;

    row_t sb[$];

    clk_div_bank #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .CH_W   (CH_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr),
        .ch_sel  (ch_sel),
        .div_in  (div_in),
        .en      (en),
        .tick    (tick),
        .clk_out (clk_out),
        .pending (pending)
`ifdef CLK_DIV_BANK_SYNC_EN
        ,
        .sync_in (sync_in)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic push_row(input logic [3:0] en_v, input logic wr_v, input logic [2:0] sel_v,
                            input logic [7:0] din_v, input logic sync_v, input logic [3:0] t_v,
                            input logic [3:0] c_v, input logic [3:0] p_v, input logic chk_v);
        row_t r;
        r.en = en_v; r.wr = wr_v; r.sel = sel_v; r.din = din_v; r.sync = sync_v;
        r.tick = t_v; r.clko = c_v; r.pend = p_v; r.chk = chk_v;
        sb.push_back(r);
    endtask

    task automatic drive(input row_t r);
        en     = r.en;
        wr     = r.wr;
        ch_sel = r.sel;
        div_in = r.din;
`ifdef CLK_DIV_BANK_SYNC_EN
        sync_in = r.sync;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 4'h1; wr = 1'b0; ch_sel = '0; div_in = '0;
`ifdef CLK_DIV_BANK_SYNC_EN
        sync_in = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({tick, clk_out, pending} !== 12'h000) begin
            bad++;
            $display("FAIL reset_hold tick=%b clk_out=%b pending=%b expected all zero", tick, clk_out, pending);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; en = 4'h0; wr = 1'b1; ch_sel = 3'd0; div_in = 8'd4;
        @(posedge clk); #1;
        wr = 1'b0; en = 4'h1;            // ch0 cnt=0
        @(posedge clk); #1;              // cnt=1
        @(posedge clk); #1;              // cnt=2
        @(negedge clk);
        total++;
        if ({tick, clk_out, pending} !== {4'h0, 4'h1, 4'h0}) begin
            bad++;
            $display("FAIL reset_midrun tick=%b clk_out=%b pending=%b expected 0000 0001 0000", tick, clk_out, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({tick, clk_out, pending} !== 12'h000) begin
            bad++;
            $display("FAIL reset_async tick=%b clk_out=%b pending=%b expected all zero", tick, clk_out, pending);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({tick, clk_out, pending} !== {4'h1, 4'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset_release tick=%b clk_out=%b pending=%b expected 0001 0000 0000", tick, clk_out, pending);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if ({tick, clk_out, pending} !== {4'h1, 4'h1, 4'h0}) begin
                bad++;
                $display("FAIL reset_n1_run cyc=%0d tick=%b clk_out=%b pending=%b expected 0001 0001 0000", i, tick, clk_out, pending);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ratios();
        int n[4] = '{1, 2, 3, 256};
        int m;
        int idx = 0;
        logic [3:0] t, c;
        row_t r;
        push_row(4'h0, 1'b0, 3'd0, 8'd0,   1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        push_row(4'h0, 1'b1, 3'd0, 8'd0,   1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        push_row(4'h0, 1'b1, 3'd1, 8'd1,   1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        push_row(4'h0, 1'b1, 3'd2, 8'd2,   1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        push_row(4'h0, 1'b1, 3'd3, 8'd255, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 600; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                m     = k % n[ch];
                t[ch] = (m == n[ch] - 1);
                c[ch] = (k != 0) && (m < (n[ch] + 1) / 2);
            end
            push_row(4'hF, 1'b0, 3'd0, 8'd0, 1'b0, t, c, 4'h0, 1'b1);
        end
        while (sb.size() != 0) begin
            r = sb.pop_front();
            drive(r);
            @(negedge clk);
            if (r.chk) begin
                total++;
                if ({tick, clk_out, pending} !== {r.tick, r.clko, r.pend}) begin
                    bad++;
                    $display("FAIL ratios row=%0d tick=%b clk_out=%b pending=%b expected %b %b %b",
                             idx, tick, clk_out, pending, r.tick, r.clko, r.pend);
                end
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_shadow();
        int m;
        int idx = 0;
        logic t, c, p;
        row_t r;
        push_row(4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        push_row(4'h0, 1'b1, 3'd1, 8'd5, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k <= 5) begin
                m = k % 6; t = (m == 5); c = (k != 0) && (m < 3); p = (k >= 3);
            end else begin
                m = (k - 6) % 2; t = (m == 1); c = (m == 0); p = 1'b0;
            end
            push_row(4'b0010, (k == 2), 3'd1, 8'd1, 1'b0,
                     {2'b00, t, 1'b0}, {2'b00, c, 1'b0}, {2'b00, p, 1'b0}, 1'b1);
        end
        while (sb.size() != 0) begin
            r = sb.pop_front();
            drive(r);
            @(negedge clk);
            if (r.chk) begin
                total++;
                if ({tick, clk_out, pending} !== {r.tick, r.clko, r.pend}) begin
                    bad++;
                    $display("FAIL shadow row=%0d tick=%b clk_out=%b pending=%b expected %b %b %b",
                             idx, tick, clk_out, pending, r.tick, r.clko, r.pend);
                end
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_double_write();
        int m;
        int idx = 0;
        logic t, c, p, w;
        logic [7:0] d;
        row_t r;
        push_row(4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        push_row(4'h0, 1'b1, 3'd2, 8'd4, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 17; k++) begin
            if (k <= 4) begin
                m = k; t = (m == 4); c = (k != 0) && (m < 3); p = (k >= 2);
            end else if (k <= 8) begin
                m = (k - 5) % 4; t = (m == 3); c = (m < 2); p = 1'b0;
            end else begin
                m = (k - 9) % 2; t = (m == 1); c = (m == 0); p = 1'b0;
            end
            w = (k == 1) || (k == 2) || (k == 8);
            d = (k == 1) ? 8'd7 : (k == 2) ? 8'd3 : 8'd1;
            push_row(4'b0100, w, 3'd2, d, 1'b0,
                     {1'b0, t, 2'b00}, {1'b0, c, 2'b00}, {1'b0, p, 2'b00}, 1'b1);
        end
        while (sb.size() != 0) begin
            r = sb.pop_front();
            drive(r);
            @(negedge clk);
            if (r.chk) begin
                total++;
                if ({tick, clk_out, pending} !== {r.tick, r.clko, r.pend}) begin
                    bad++;
                    $display("FAIL double_write row=%0d tick=%b clk_out=%b pending=%b expected %b %b %b",
                             idx, tick, clk_out, pending, r.tick, r.clko, r.pend);
                end
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_disable_oor();
        int m;
        int idx = 0;
        logic t3, c3, p3, t1, c1, w;
        logic [3:0] e;
        logic [2:0] s;
        logic [7:0] d;
        row_t r;
        push_row(4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        push_row(4'h0, 1'b1, 3'd3, 8'd3, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 21; k++) begin
            t1 = 1'b0; c1 = 1'b0;
            if (k <= 6) begin
                e = 4'b1000;
                m = k % 4; t3 = (m == 3); c3 = (k != 0) && (m < 2); p3 = (k == 6);
            end else if (k <= 10) begin
                e = 4'b0000;
                t3 = 1'b0; c3 = 1'b0; p3 = (k == 7);
            end else begin
                e = 4'b1010;
                m = (k - 11) % 3; t3 = (m == 2); c3 = (k != 11) && (m < 2); p3 = 1'b0;
                m = (k - 11) % 2; t1 = (m == 1); c1 = (k != 11) && (m == 0);
            end
            w = (k == 5) || (k == 9) || (k == 12);
            s = (k == 12) ? 3'd5 : 3'd3;
            d = (k == 5) ? 8'd1 : (k == 9) ? 8'd2 : 8'd0;
            push_row(e, w, s, d, 1'b0,
                     {t3, 1'b0, t1, 1'b0}, {c3, 1'b0, c1, 1'b0}, {p3, 3'b000}, 1'b1);
        end
        while (sb.size() != 0) begin
            r = sb.pop_front();
            drive(r);
            @(negedge clk);
            if (r.chk) begin
                total++;
                if ({tick, clk_out, pending} !== {r.tick, r.clko, r.pend}) begin
                    bad++;
                    $display("FAIL disable_oor row=%0d tick=%b clk_out=%b pending=%b expected %b %b %b",
                             idx, tick, clk_out, pending, r.tick, r.clko, r.pend);
                end
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

`ifdef CLK_DIV_BANK_SYNC_EN
    task automatic test_sync();
        int n[2] = '{4, 6};
        int m;
        int idx = 0;
        logic [3:0] t, c;
        row_t r;
        push_row(4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        push_row(4'h0, 1'b1, 3'd0, 8'd3, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        push_row(4'h0, 1'b1, 3'd1, 8'd5, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 15; k++) begin
            t = 4'h0; c = 4'h0;
            for (int ch = 0; ch < 2; ch++) begin
                m     = (k <= 3) ? (k % n[ch]) : ((k - 4) % n[ch]);
                t[ch] = (m == n[ch] - 1) && (k != 3);
                c[ch] = (k != 0) && (m < (n[ch] + 1) / 2);
            end
            push_row(4'b0011, 1'b0, 3'd0, 8'd0, (k == 3), t, c, 4'h0, 1'b1);
        end
        while (sb.size() != 0) begin
            r = sb.pop_front();
            drive(r);
            @(negedge clk);
            if (r.chk) begin
                total++;
                if ({tick, clk_out, pending} !== {r.tick, r.clko, r.pend}) begin
                    bad++;
                    $display("FAIL sync row=%0d tick=%b clk_out=%b pending=%b expected %b %b %b",
                             idx, tick, clk_out, pending, r.tick, r.clko, r.pend);
                end
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ratios();
        test_shadow();
        test_double_write();
        test_disable_oor();
`ifdef CLK_DIV_BANK_SYNC_EN
        test_sync();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
